input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Front-end stage between the raw board inputs (KEY button, slide switches) and the safe's state machine.
- Synchronises every raw input with 2 flops and debounces each one independently.
- Freezes the password nibble while the send button is held.
- Delivers glitch-free levels A, B, SAF, H, reset_senha and senha, plus a one-cycle press strobe and a press counter for diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before an output follows its input (10 ms at 50 MHz). Legal minimum is 2.
- CNT_W, 19: width of each debounce counter. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all registers on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- key_b  in  1  raw send button, active-low (pressed = 0)
- sw_a  in  1  raw mode switch
- sw_saf  in  1  raw remote key switch
- sw_h  in  1  raw emergency switch
- sw_rs  in  1  raw password-reset switch
- sw_senha  in  4  raw password switches SW3..SW0
- B  out  1  debounced button level, idle 1, pressed 0
- A  out  1  debounced mode level
- SAF  out  1  debounced remote key
- H  out  1  debounced emergency
- reset_senha  out  1  debounced password-reset
- senha  out  4  debounced password, frozen while B=0
- press_pulse  out  1  one-cycle strobe on debounced press
- press_count  out  8  saturating count of debounced presses

Behaviour:
- Reset (reset=0, asynchronous):
  - B chain: sync flops and output reset to 1.
  - All other sync flops and outputs reset to 0; senha=0.
  - press_pulse=0, press_count=0, all counters 0.
  - Asserting reset mid-debounce discards the partial count.
  - Release is synchronous in effect: the first edge after reset=1 samples normally.
- Channels: 9 independent bits (B, A, SAF, H, reset_senha, senha[3:0]). Each has sync1 -> sync2 -> debounce counter -> output register.
- Debounce rule, per channel, each edge:
  - If sync2 == out: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: out <= sync2, counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to the output value restarts the count from 0.
- Latency: a raw change first captured into sync1 at edge k appears in sync2 at edge k+1. The output flips at edge k+DEBOUNCE_CYCLES+1, provided the raw input holds through edge k+DEBOUNCE_CYCLES.
- Pulses shorter than DEBOUNCE_CYCLES cycles (after sync) never reach the output.
- Senha freeze: each senha bit still runs its debounce counter, but the senha output register loads only on edges where the current B output is 1. While B=0, senha holds its value. A senha bit whose debounce completes while B=0 loads on the first edge after B returns to 1, provided sync2 still differs.
- press_pulse:
  - Registered; 1 for exactly the cycle in which B has just transitioned 1->0 (same edge B updates), otherwise 0.
  - Release (0->1) produces no pulse.
  - Holding the button produces one pulse only.
- press_count:
  - Increments on the same edge press_pulse goes high.
  - Saturates at 255.
  - Cleared only by reset.
- Simultaneous events: channels are fully independent. A and B may change on the same edge. No priority between channels.
- No combinational path from any input port to any output port.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset check: hold reset=0, toggle all raw inputs -> B=1, all other outputs 0, press_count=0. Release reset with key_b=1 and switches 0 -> outputs unchanged.
- Clean press: key_b 1->0 held 20 cycles, captured at edge k -> B=0 exactly at edge k+5. press_pulse=1 for that single cycle, press_count=1. key_b back to 1 -> B=1 five edges later, no pulse.
- Bounce rejection: key_b pattern 0,0,0,1,0,0,0,1 repeating for 40 cycles -> B stays 1, press_pulse never asserts, press_count stays 0.
- Senha freeze: sw_senha=4'b1010 settled, press and hold key_b, then set sw_senha=4'b0101 while B=0 -> senha holds 1010 until B returns to 1. It becomes 0101 on the first edge with B=1.
- Saturation: 260 clean presses -> press_count reads 255, press_pulse still fires on every press.
- Mid-operation reset: sw_a 0->1, assert reset after 2 stable cycles, release, keep sw_a=1 -> A=0 during reset, then A=1 exactly DEBOUNCE_CYCLES+1 edges after the first post-reset capture.

Source files
------------

// File: rtl/input_conditioner.sv
// Input front end for the safe controller: two-flop synchronisers and per-channel debouncers.
// It also freezes the password while the send button is held and counts button presses.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_b,
  input  logic       sw_a,
  input  logic       sw_saf,
  input  logic       sw_h,
  input  logic       sw_rs,
  input  logic [3:0] sw_senha,
  output logic       B,
  output logic       A,
  output logic       SAF,
  output logic       H,
  output logic       reset_senha,
  output logic [3:0] senha,
  output logic       press_pulse,
  output logic [7:0] press_count
);

  // Channel map: 0=B, 1=A, 2=SAF, 3=H, 4=reset_senha, 5..8=senha[0..3]
  localparam int              NCH        = 9;
  localparam int              SENHA_LO   = 5;
  localparam logic [NCH-1:0]  RST_VAL    = 9'b0_0000_0001;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_reg;
  logic [NCH-1:0] sync2_reg;
  logic [NCH-1:0] out_reg;
  logic [NCH-1:0] done;
  logic           freeze;
  logic           press_next;

  assign raw    = {sw_senha, sw_rs, sw_h, sw_saf, sw_a, key_b};
  assign freeze = ~out_reg[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= RST_VAL;
      sync2_reg <= RST_VAL;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
      localparam bit IS_SENHA = (gi >= SENHA_LO);
      logic [CNT_W-1:0] cnt_reg;
      logic             out_bit_reg;

      assign done[gi]    = (sync2_reg[gi] != out_bit_reg) && (cnt_reg == CNT_LAST);
      assign out_reg[gi] = out_bit_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg     <= '0;
          out_bit_reg <= RST_VAL[gi];
        end else if (sync2_reg[gi] == out_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          // A frozen password bit parks at the final count so it loads once B releases.
          if (!(IS_SENHA && freeze)) begin
            out_bit_reg <= sync2_reg[gi];
            cnt_reg     <= '0;
          end
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // B is about to fall on this edge when its debounce completes while it is still 1.
  assign press_next = out_reg[0] & done[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_pulse <= 1'b0;
      press_count <= 8'd0;
    end else begin
      press_pulse <= press_next;
      if (press_next && (press_count != 8'hFF))
        press_count <= press_count + 8'd1;
    end
  end

  assign B           = out_reg[0];
  assign A           = out_reg[1];
  assign SAF         = out_reg[2];
  assign H           = out_reg[3];
  assign reset_senha = out_reg[4];
  assign senha       = out_reg[8:5];

endmodule
